// File: rtl/tinker_fetch.sv
// Tinker instruction fetch stage: owns the PC, reads the RAM port and presents
// one registered instruction (or fault marker) to decode over valid/ready.
module tinker_fetch #(
  parameter logic [63:0] RESET_PC = 64'h2000,
  parameter int unsigned MEM_SIZE = 524288
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_error,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt_req,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_fault,
  output logic        halted,
  output logic [31:0] inst_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [63:0] LAST_ADDR = 64'(MEM_SIZE) - 64'd4;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [63:0] r_inst_pc;
  logic        r_inst_fault;
  logic [31:0] r_inst_count;

  logic w_accept;
  logic w_slot_free;
  logic w_bad;
  logic w_halt;
  logic w_redirect;
  logic w_fetch;

  assign w_accept    = r_inst_valid & inst_ready;
  assign w_slot_free = ~r_inst_valid | inst_ready;
  assign w_bad       = mem_error | (r_pc[1:0] != 2'b00) | (r_pc > LAST_ADDR);

  // Once halted, both halt_req and redirect_valid are ignored until reset.
  assign w_halt     = halt_req & (r_state != ST_HALTED);
  assign w_redirect = redirect_valid & ~halt_req & (r_state != ST_HALTED);
  assign w_fetch    = (r_state == ST_RUN) & ~redirect_valid & ~halt_req & w_slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 64'd0;
      r_inst_fault <= 1'b0;
      r_inst_count <= 32'd0;
    end else begin
      if (w_accept && (r_inst_count != 32'hFFFF_FFFF)) begin
        r_inst_count <= r_inst_count + 32'd1;
      end

      if (w_halt) begin
        r_state      <= ST_HALTED;
        r_inst_valid <= 1'b0;
      end else if (w_redirect) begin
        r_state      <= ST_RUN;
        r_pc         <= redirect_pc;
        r_inst_valid <= 1'b0;
      end else if (w_fetch) begin
        r_inst_valid <= 1'b1;
        r_inst_pc    <= r_pc;
        if (w_bad) begin
          // Fault marker: PC stays on the faulting address until redirected.
          r_inst       <= 32'd0;
          r_inst_fault <= 1'b1;
          r_state      <= ST_HOLD;
        end else begin
          r_inst       <= mem_data;
          r_inst_fault <= 1'b0;
          r_pc         <= r_pc + 64'd4;
        end
      end else if (w_accept) begin
        r_inst_valid <= 1'b0;
      end
    end
  end

  assign mem_addr   = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_fault = r_inst_fault;
  assign halted     = (r_state == ST_HALTED);
  assign inst_count = r_inst_count;

endmodule

// File: tb/tb_tinker_fetch.sv
// Scoreboard bench for tinker_fetch: expected entries are queued as stimulus is
// driven and popped on every accepted handshake; timing points checked inline.
module tb_tinker_fetch;

  logic        clk;
  logic        reset;
  logic [63:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_error;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt_req;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        halted;
  logic [31:0] inst_count;

  typedef struct packed {
    logic        fault;
    logic [63:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      sb_q[$];
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_count;

  tinker_fetch dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_error(mem_error), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault), .halted(halted), .inst_count(inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [63:0] a);
    if (a == 64'h2000) return 32'h1111_1111;
    if (a == 64'h2004) return 32'h2222_2222;
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  assign mem_data = ram_word(mem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic fault, input logic [63:0] pc, input logic [31:0] word);
    entry_t e;
    e.fault = fault;
    e.pc    = pc;
    e.word  = word;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable at the falling edge, so this sees exactly the handshakes
  // the DUT will count at the next rising edge.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      entry_t e;
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_inst", 64'(inst), 64'(e.word));
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_fault", 64'(inst_fault), 64'(e.fault));
      end
      exp_count = exp_count + 32'd1;
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_addr"}, mem_addr, 64'h2000);
    chk({tag, "_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_inst"}, 64'(inst), 64'd0);
    chk({tag, "_pc"}, inst_pc, 64'd0);
    chk({tag, "_fault"}, 64'(inst_fault), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_count"}, 64'(inst_count), 64'd0);
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    chk("redir_bubble", 64'(inst_valid), 64'd0);
    chk("redir_addr", mem_addr, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_count = 32'd0;
    reset = 1'b1;
    inst_ready = 1'b1;
    mem_error = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    halt_req = 1'b0;
    tick();
    tick();
    check_reset_state("rst");

    // Sequential fetch, then a 3-cycle stall.
    push(1'b0, 64'h2000, 32'h1111_1111);
    push(1'b0, 64'h2004, 32'h2222_2222);
    push(1'b0, 64'h2008, ram_word(64'h2008));
    push(1'b0, 64'h200C, ram_word(64'h200C));
    reset = 1'b0;
    tick();
    chk("first_valid", 64'(inst_valid), 64'd1);
    chk("first_pc", inst_pc, 64'h2000);
    chk("first_inst", 64'(inst), 64'h1111_1111);
    tick();
    chk("second_pc", inst_pc, 64'h2004);
    chk("second_inst", 64'(inst), 64'h2222_2222);
    tick();
    chk("count_two", 64'(inst_count), 64'd2);
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", inst_pc, 64'h2008);
      chk("stall_inst", 64'(inst), 64'(ram_word(64'h2008)));
      chk("stall_addr", mem_addr, 64'h200C);
    end
    inst_ready = 1'b1;
    tick();
    chk("release_pc", inst_pc, 64'h200C);
    chk("release_count", 64'(inst_count), 64'(exp_count));

    // Redirect in the same cycle as an accepted handshake.
    redirect_to(64'h3000);
    chk("redir_count", 64'(inst_count), 64'(exp_count));
    tick();
    chk("redir_target_pc", inst_pc, 64'h3000);
    chk("redir_target_inst", 64'(inst), 64'(ram_word(64'h3000)));

    // Misaligned redirect while the slot is stalled: entry is flushed, then faults.
    inst_ready = 1'b0;
    redirect_to(64'h2002);
    inst_ready = 1'b1;
    push(1'b1, 64'h2002, 32'd0);
    tick();
    chk("mis_fault", 64'(inst_fault), 64'd1);
    chk("mis_pc", inst_pc, 64'h2002);
    chk("mis_inst", 64'(inst), 64'd0);
    tick();
    chk("hold_valid", 64'(inst_valid), 64'd0);
    tick();
    chk("hold_valid2", 64'(inst_valid), 64'd0);
    chk("hold_addr", mem_addr, 64'h2002);

    // Resume from HOLD.
    push(1'b0, 64'h2000, 32'h1111_1111);
    redirect_to(64'h2000);
    tick();
    chk("resume_pc", inst_pc, 64'h2000);

    // Out-of-range redirects; the handshake on 0x2000 still counts.
    push(1'b1, 64'h7FFFE, 32'd0);
    redirect_to(64'h7FFFE);
    tick();
    chk("top_fault", 64'(inst_fault), 64'd1);
    chk("top_pc", inst_pc, 64'h7FFFE);
    tick();
    chk("top_hold", 64'(inst_valid), 64'd0);

    push(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'd0);
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_fault", 64'(inst_fault), 64'd1);
    chk("wrap_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_hold", 64'(inst_valid), 64'd0);

    // Last legal word is fetched normally; the next address faults.
    push(1'b0, 64'h7FFFC, ram_word(64'h7FFFC));
    push(1'b1, 64'h80000, 32'd0);
    redirect_to(64'h7FFFC);
    tick();
    chk("edge_ok_pc", inst_pc, 64'h7FFFC);
    chk("edge_ok_fault", 64'(inst_fault), 64'd0);
    tick();
    chk("edge_bad_pc", inst_pc, 64'h80000);
    chk("edge_bad_fault", 64'(inst_fault), 64'd1);
    tick();
    chk("edge_hold", 64'(inst_valid), 64'd0);
    chk("edge_addr", mem_addr, 64'h80000);

    // RAM-reported error.
    redirect_to(64'h2004);
    mem_error = 1'b1;
    push(1'b1, 64'h2004, 32'd0);
    tick();
    mem_error = 1'b0;
    chk("err_fault", 64'(inst_fault), 64'd1);
    chk("err_inst", 64'(inst), 64'd0);
    tick();
    chk("err_hold", 64'(inst_valid), 64'd0);

    // Halt beats a simultaneous redirect; handshake in that cycle counts.
    push(1'b0, 64'h2000, 32'h1111_1111);
    redirect_to(64'h2000);
    tick();
    chk("pre_halt_valid", 64'(inst_valid), 64'd1);
    halt_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    tick();
    halt_req = 1'b0;
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_valid", 64'(inst_valid), 64'd0);
    chk("halt_addr", mem_addr, 64'h2004);
    chk("halt_count", 64'(inst_count), 64'(exp_count));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted_valid", 64'(inst_valid), 64'd0);
      chk("halted_addr", mem_addr, 64'h2004);
      chk("halted_flag", 64'(halted), 64'd1);
    end
    redirect_valid = 1'b0;

    // Reset clears everything.
    reset = 1'b1;
    tick();
    check_reset_state("rst2");
    exp_count = 32'd0;
    inst_ready = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_rst_valid", 64'(inst_valid), 64'd1);
    chk("post_rst_pc", inst_pc, 64'h2000);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
